// File: rtl/inst_fetch_unit.sv
// Fetch unit for an asynchronous instruction ROM. It holds the PC, captures ROM words into a
// small in-order queue, and presents the queue head to decode with a valid/ready handshake.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ROM_DEPTH = 20,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned FQ_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              fetch_halt
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] FQ_FULL   = CNT_W'(FQ_DEPTH);
  localparam logic [29:0]      ROM_LIMIT = 30'(ROM_DEPTH);

  logic [31:0]      fetch_pc_p0;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      fq_pc_p0   [FQ_DEPTH];
  logic [31:0]      fq_inst_p0 [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      head_pc_p1, head_inst_p1;
  logic [31:0]      head_pc_nxt, head_inst_nxt;
  logic             head_load;
  logic             fetch_oor;
  logic             vld_p1;
  logic             pop;
  logic             push;

  // ---- stage p0: PC drives the ROM; the returned word is pushed in the same cycle ----
  assign fetch_oor  = (fetch_pc_p0[31:2] >= ROM_LIMIT);
  assign fetch_halt = fetch_oor;
  assign inst_addr  = fetch_pc_p0[ADDR_W+1:2];

  assign vld_p1 = (count != '0);
  assign pop    = vld_p1 & id_ready;
  assign push   = !fetch_oor & !br_taken & ((count < FQ_FULL) | pop);

  always_comb begin
    fetch_pc_nxt = fetch_pc_p0;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count;
    if (br_taken) begin
      // Redirect wins over push and pop; a same-cycle pop is simply dropped.
      fetch_pc_nxt = br_target & 32'hFFFF_FFFC;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
    end else begin
      if (push) begin
        fetch_pc_nxt = fetch_pc_p0 + 32'd4;
        wr_ptr_nxt   = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // The head register mirrors the entry at the next read pointer; when that entry is the one
  // being written this cycle, take it straight from the ROM so there is no bubble.
  always_comb begin
    head_load     = (count_nxt != '0);
    head_pc_nxt   = fq_pc_p0[rd_ptr_nxt];
    head_inst_nxt = fq_inst_p0[rd_ptr_nxt];
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_pc_nxt   = fetch_pc_p0;
      head_inst_nxt = inst_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_p0 <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      fetch_pc_p0 <= fetch_pc_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_p0[wr_ptr]   <= fetch_pc_p0;
      fq_inst_p0[wr_ptr] <= inst_rdata;
    end
  end

  // ---- stage p1: registered queue head toward decode ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_pc_p1   <= '0;
      head_inst_p1 <= '0;
    end else if (head_load) begin
      head_pc_p1   <= head_pc_nxt;
      head_inst_p1 <= head_inst_nxt;
    end
  end

  assign id_valid = vld_p1;
  assign id_pc    = head_pc_p1;
  assign id_inst  = head_inst_p1;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!resetn) count <= FQ_FULL);
  a_head_stable: assert property (@(posedge clk) disable iff (!resetn)
    (vld_p1 && !id_ready && !br_taken) |=> ($stable(head_pc_p1) && $stable(head_inst_p1)));
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: ROM model, scoreboard of expected {pc, inst} heads, and one
// task per scenario covering streaming, backpressure, redirects, halt and async reset.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  inst_addr;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        fetch_halt;

  logic [31:0] rom [32];
  logic [63:0] sb [$];
  logic [63:0] e;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign inst_rdata = rom[inst_addr];

  inst_fetch_unit #(.ADDR_W(5), .ROM_DEPTH(20), .RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .br_taken(br_taken), .br_target(br_target), .fetch_halt(fetch_halt)
  );

  task automatic push_exp(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc + 32'(4 * i);
      sb.push_back({p, rom[p[6:2]]});
    end
  endtask

  task automatic do_reset(input logic rdy);
    resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; id_ready = rdy;
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({id_valid, fetch_halt} !== 2'b00) begin
      errors++; $display("FAIL reset_ctl got valid=%b halt=%b exp 0 0", id_valid, fetch_halt);
    end
    checks++;
    if ({id_pc, id_inst, inst_addr} !== 69'h0) begin
      errors++; $display("FAIL reset_data got pc=%h inst=%h addr=%0d exp 0", id_pc, id_inst, inst_addr);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    push_exp(32'h0, 3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, e}) begin
        errors++; $display("FAIL stream got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                           id_valid, id_pc, id_inst, e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0, 32'h2401000A}) begin
        errors++; $display("FAIL stall_head got v=%b pc=%h inst=%h exp pc=0 inst=2401000a",
                           id_valid, id_pc, id_inst);
      end
    end
    checks++;
    if (inst_addr !== 5'd2) begin
      errors++; $display("FAIL stall_pc got addr=%0d exp 2", inst_addr);
    end
    id_ready = 1'b1;
    push_exp(32'h0, 4);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front(); checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, e}) begin
        errors++; $display("FAIL release got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                           id_valid, id_pc, id_inst, e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    br_taken = 1'b1; br_target = 32'h0000000E;
    @(negedge clk);
    br_taken = 1'b0;
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty got valid=%b exp 0", id_valid);
    end
    checks++;
    if (inst_addr !== 5'd3) begin
      errors++; $display("FAIL flush_addr got addr=%0d exp 3", inst_addr);
    end
    @(negedge clk);
    id_ready = 1'b1;
    push_exp(32'h0000000C, 2);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, e}) begin
        errors++; $display("FAIL redirect got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                           id_valid, id_pc, id_inst, e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    push_exp(32'h0, 20);
    @(negedge clk);
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      if (id_valid) begin
        e = sb.pop_front(); checks++;
        if ({id_pc, id_inst} !== e) begin
          errors++; $display("FAIL freerun got pc=%h inst=%h exp pc=%h inst=%h",
                             id_pc, id_inst, e[63:32], e[31:0]);
        end
      end
      if (sb.size() > 0) @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL freerun_timeout got remaining=%0d exp 0", sb.size());
    end
    checks++;
    if ({fetch_halt, inst_addr} !== {1'b1, 5'd20}) begin
      errors++; $display("FAIL halt_set got halt=%b addr=%0d exp 1 20", fetch_halt, inst_addr);
    end
    @(negedge clk);
    checks++;
    if ({id_valid, fetch_halt} !== 2'b01) begin
      errors++; $display("FAIL halt_drained got valid=%b halt=%b exp 0 1", id_valid, fetch_halt);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({id_valid, fetch_halt} !== 2'b01) begin
      errors++; $display("FAIL halt_idle got valid=%b halt=%b exp 0 1", id_valid, fetch_halt);
    end
    br_taken = 1'b1; br_target = 32'h0;
    @(negedge clk);
    br_taken = 1'b0;
    checks++;
    if (fetch_halt !== 1'b0) begin
      errors++; $display("FAIL halt_clear got halt=%b exp 0", fetch_halt);
    end
    push_exp(32'h0, 2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, e}) begin
        errors++; $display("FAIL restart got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                           id_valid, id_pc, id_inst, e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_pop_oor();
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (id_valid !== 1'b1) begin
      errors++; $display("FAIL bp_pre got valid=%b exp 1", id_valid);
    end
    br_taken = 1'b1; br_target = 32'h00000100;
    @(negedge clk);
    br_taken = 1'b0;
    checks++;
    if ({id_valid, fetch_halt} !== 2'b01) begin
      errors++; $display("FAIL bp_flush got valid=%b halt=%b exp 0 1", id_valid, fetch_halt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({id_valid, fetch_halt} !== 2'b01) begin
        errors++; $display("FAIL bp_hold got valid=%b halt=%b exp 0 1", id_valid, fetch_halt);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    br_taken = 1'b1; br_target = 32'h00000048;
    @(negedge clk);
    br_taken = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({id_valid, fetch_halt, id_pc} !== {2'b11, 32'h48}) begin
      errors++; $display("FAIL ar_pre got valid=%b halt=%b pc=%h exp 1 1 00000048",
                         id_valid, fetch_halt, id_pc);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({id_valid, fetch_halt, id_pc, id_inst} !== 66'h0) begin
      errors++; $display("FAIL ar_immediate got valid=%b halt=%b pc=%h inst=%h exp 0",
                         id_valid, fetch_halt, id_pc, id_inst);
    end
    @(negedge clk);
    resetn = 1'b1; id_ready = 1'b1;
    sb.delete();
    push_exp(32'h0, 2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, e}) begin
        errors++; $display("FAIL ar_resume got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                           id_valid, id_pc, id_inst, e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h3C00_0000 | 32'(i);
    rom[0] = 32'h2401000A;
    rom[1] = 32'h24020014;
    rom[2] = 32'h00221821;
    rom[3] = 32'h24040007;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_branch_pop_oor();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
